// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM bus arbiter: requester IDs, access sizes
// and the outstanding-count width helper.
package sram_bus_pkg;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_sel_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Width that holds 0..depth inclusive, so a full FIFO is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/req_id_fifo.sv
// 1-bit requester-ID FIFO recording who owns each accepted, unanswered transaction.
// Pointers wrap naturally because DEPTH is a power of two.
module req_id_fifo
    import sram_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic          din,
    output logic          head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] ids;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = ids[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) ids[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between instruction fetch and data access: data wins,
// a stalled request keeps the grant, responses are routed back in accept order.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int CW = cnt_width(MAX_OUTSTANDING);

    req_sel_e      sel;
    req_sel_e      lock_sel;
    logic          lock_valid;
    logic          sel_req;
    logic          accept;
    logic          fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          resp_valid;
    logic [CW-1:0] unused_fifo_count;

    assign unused_fifo_count = fifo_count;

    always_comb begin
        sel = REQ_INST;
        if (lock_valid)    sel = lock_sel;
        else if (data_req) sel = REQ_DATA;
        else if (inst_req) sel = REQ_INST;
        sel_req = (sel == REQ_DATA) ? data_req : inst_req;
    end

    // Outputs are gated by resetn so nothing handshakes during a reset cycle.
    assign mem_req      = resetn & sel_req & ~fifo_full;
    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (sel == REQ_INST);
    assign data_addr_ok = accept & (sel == REQ_DATA);

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = SIZE_WORD;
        mem_wstrb = 4'h0;
        mem_addr  = inst_addr;
        mem_wdata = 32'h0;
        if (sel == REQ_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_sel   <= REQ_INST;
        end else if (accept) begin
            lock_valid <= 1'b0;
        end else if (mem_req) begin
            lock_valid <= 1'b1;
            lock_sel   <= sel;
        end
    end

    req_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (mem_data_ok),
        .din    (sel),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // A response with nothing outstanding is dropped, even if a push lands this cycle.
    assign resp_valid   = resetn & mem_data_ok & ~fifo_empty;
    assign inst_data_ok = resp_valid & (fifo_head == REQ_INST);
    assign data_data_ok = resp_valid & (fifo_head == REQ_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule
